// File: rtl/m_axi_lite_arb.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NREQ single-command clients.
// The winner's command is captured at grant; done/resp_err pulse to the owner for one cycle.
module m_axi_lite_arb #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 32,
    parameter int REG_WIDTH = 32,
    parameter int OWN_BIT   = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ-1:0]           we_i,
    input  logic [NREQ*REG_WIDTH-1:0] addr_i,
    input  logic [NREQ*DWIDTH-1:0]    wdata_i,
    output logic [NREQ-1:0]           done_o,
    output logic [NREQ-1:0]           resp_err_o,
    output logic [DWIDTH-1:0]         rdata_o,
    output logic                      busy_o,
    output logic [OWN_BIT-1:0]        owner_o,
    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [REG_WIDTH-1:0]      awaddr_o,
    output logic [2:0]                awprot_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    output logic [DWIDTH-1:0]         wdata_o,
    output logic [DWIDTH/8-1:0]       wstrb_o,
    input  logic                      bvalid_i,
    output logic                      bready_o,
    input  logic [1:0]                bresp_i,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    output logic [REG_WIDTH-1:0]      araddr_o,
    output logic [2:0]                arprot_o,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    input  logic [DWIDTH-1:0]         rdata_i,
    input  logic [1:0]                rresp_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [OWN_BIT-1:0]     owner_q, owner_d;
    logic [OWN_BIT-1:0]     rr_q, rr_d;
    logic [REG_WIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]      wdat_q, wdat_d;
    logic                   err_q, err_d;
    logic [DWIDTH-1:0]      rdata_q, rdata_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   bready_q, bready_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;

    logic [REG_WIDTH-1:0]   addr_arr  [NREQ];
    logic [DWIDTH-1:0]      wdata_arr [NREQ];
    logic                   grant_vld;
    logic [OWN_BIT-1:0]     winner;
    logic [NREQ-1:0]        owner_onehot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*REG_WIDTH +: REG_WIDTH];
            assign wdata_arr[gi] = wdata_i[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    // Search starts just after the last winner so it becomes lowest priority next time.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        winner    = rr_q;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_vld && req_i[idx[OWN_BIT-1:0]]) begin
                grant_vld = 1'b1;
                winner    = idx[OWN_BIT-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d = winner;
                    rr_d    = winner;
                    addr_d  = addr_arr[winner];
                    wdat_d  = wdata_arr[winner];
                    if (we_i[winner]) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WADDR: begin
                if (awready_i) awvalid_d = 1'b0;
                if (wready_i)  wvalid_d  = 1'b0;
                if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                if (bvalid_i) begin
                    state_d  = S_DONE;
                    bready_d = 1'b0;
                    // SLVERR and DECERR both carry resp bit 1
                    err_d    = (bresp_i & 2'b10) != 2'b00;
                end
            end
            S_RADDR: begin
                if (arready_i) begin
                    state_d   = S_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RDATA: begin
                if (rvalid_i) begin
                    state_d  = S_DONE;
                    rready_d = 1'b0;
                    rdata_d  = rdata_i;
                    err_d    = (rresp_i & 2'b10) != 2'b00;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            rr_q      <= OWN_BIT'(NREQ - 1);
            addr_q    <= '0;
            wdat_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign owner_onehot = NREQ'(1) << owner_q;
    assign done_o       = (state_q == S_DONE) ? owner_onehot : '0;
    assign resp_err_o   = (state_q == S_DONE && err_q) ? owner_onehot : '0;
    assign busy_o       = (state_q != S_IDLE);
    assign owner_o      = owner_q;
    assign rdata_o      = rdata_q;

    assign awvalid_o = awvalid_q;
    assign awaddr_o  = addr_q;
    assign awprot_o  = 3'b000;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdat_q;
    assign wstrb_o   = '1;
    assign bready_o  = bready_q;
    assign arvalid_o = arvalid_q;
    assign araddr_o  = addr_q;
    assign arprot_o  = 3'b001;
    assign rready_o  = rready_q;

endmodule

// File: tb/tb_m_axi_lite_arb.sv
// Randomized bench for m_axi_lite_arb: random clients and AXI-Lite slave, checked each cycle
// against a transaction-level model of arbitration order, handshake timing and completion.
module tb_m_axi_lite_arb;

    localparam int NREQ   = 4;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int OB     = 2;
    localparam int M_IDLE = 0;
    localparam int M_XFER = 1;
    localparam int M_DONE = 2;

    logic               clk = 1'b0;
    logic               xrst;
    logic [NREQ-1:0]    req, we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    done, resp_err;
    logic [DW-1:0]      rdata_o;
    logic               busy;
    logic [OB-1:0]      owner;
    logic               awvalid, awready, wvalid, wready, bvalid, bready;
    logic               arvalid, arready, rvalid, rready;
    logic [AW-1:0]      awaddr, araddr;
    logic [2:0]         awprot, arprot;
    logic [DW-1:0]      axi_wdata, axi_rdata;
    logic [DW/8-1:0]    wstrb;
    logic [1:0]         bresp, rresp;

    always #5 clk = ~clk;

    m_axi_lite_arb #(.NREQ(NREQ), .DWIDTH(DW), .REG_WIDTH(AW)) dut (
        .clk(clk), .xrst(xrst),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .done_o(done), .resp_err_o(resp_err), .rdata_o(rdata_o), .busy_o(busy), .owner_o(owner),
        .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr), .awprot_o(awprot),
        .wvalid_o(wvalid), .wready_i(wready), .wdata_o(axi_wdata), .wstrb_o(wstrb),
        .bvalid_i(bvalid), .bready_o(bready), .bresp_i(bresp),
        .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arprot_o(arprot),
        .rvalid_i(rvalid), .rready_o(rready), .rdata_i(axi_rdata), .rresp_i(rresp)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int          m_st, m_owner, last_win;
    logic        m_we, m_err, aw_pend, w_pend, ar_pend;
    logic [31:0] m_addr, m_wdata, exp_rdata;
    // slave model state
    logic        s_got_aw, s_got_w, s_got_ar;
    int          s_bdly, s_rdly;
    // stimulus control and next-cycle input values
    logic        fast, contend, rst_pending;
    logic [NREQ-1:0]    n_req, n_we;
    logic [NREQ*AW-1:0] n_addr;
    logic [NREQ*DW-1:0] n_wdata;
    logic        n_awready, n_wready, n_arready, n_bvalid, n_rvalid;
    logic [1:0]  n_bresp, n_rresp;
    logic [31:0] n_rdata;

    task automatic model_reset();
        m_st = M_IDLE; m_owner = 0; last_win = NREQ - 1;
        m_we = 1'b0; m_err = 1'b0; aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
        m_addr = '0; m_wdata = '0; exp_rdata = '0;
        s_got_aw = 1'b0; s_got_w = 1'b0; s_got_ar = 1'b0; s_bdly = 0; s_rdly = 0;
        n_bvalid = 1'b0; n_rvalid = 1'b0;
    endtask

    task automatic apply();
        req = n_req; we = n_we; addr = n_addr; wdata = n_wdata;
        awready = n_awready; wready = n_wready; arready = n_arready;
        bvalid = n_bvalid; bresp = n_bresp; rvalid = n_rvalid; rresp = n_rresp; axi_rdata = n_rdata;
        xrst = 1'b0;
    endtask

    // Runs in the low clock phase: check outputs, then predict the coming edge.
    task automatic eval_cycle();
        logic            aw_hs, w_hs, b_hs, ar_hs, r_hs, exp_bready, exp_rready, in_waddr, found;
        logic [NREQ-1:0] one, exp_done, exp_err, dropped;
        int              win, cand;
        one        = 1;
        exp_bready = (m_st == M_XFER) && m_we && !aw_pend && !w_pend;
        exp_rready = (m_st == M_XFER) && !m_we && !ar_pend;
        exp_done   = (m_st == M_DONE) ? (one << m_owner) : '0;
        exp_err    = (m_st == M_DONE && m_err) ? exp_done : '0;
        in_waddr   = (m_st == M_XFER) && m_we && (aw_pend || w_pend);

        check("busy", busy, m_st != M_IDLE);
        check("owner", owner, m_owner);
        check("rdata_o", rdata_o, exp_rdata);
        check("done", done, exp_done);
        check("resp_err", resp_err, exp_err);
        check("awvalid", awvalid, (m_st == M_XFER) && aw_pend);
        check("wvalid", wvalid, (m_st == M_XFER) && w_pend);
        check("arvalid", arvalid, (m_st == M_XFER) && ar_pend);
        check("bready", bready, exp_bready);
        check("rready", rready, exp_rready);
        if (m_st == M_XFER && aw_pend) begin
            check("awaddr", awaddr, m_addr);
            check("awprot", awprot, 3'b000);
        end
        if (m_st == M_XFER && w_pend) begin
            check("wdata", axi_wdata, m_wdata);
            check("wstrb", wstrb, 4'hF);
        end
        if (m_st == M_XFER && ar_pend) begin
            check("araddr", araddr, m_addr);
            check("arprot", arprot, 3'b001);
        end

        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;

        n_req = req; n_we = we; n_addr = addr; n_wdata = wdata; dropped = '0;
        n_awready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
        n_wready  = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
        n_arready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);

        // slave: B after both AW and W accepted, R after AR, each after a random delay
        n_bvalid = bvalid; n_bresp = bresp; n_rvalid = rvalid; n_rresp = rresp; n_rdata = axi_rdata;
        if (aw_hs) s_got_aw = 1'b1;
        if (w_hs)  s_got_w  = 1'b1;
        if (b_hs) begin
            n_bvalid = 1'b0; s_got_aw = 1'b0; s_got_w = 1'b0;
        end else if (!bvalid && s_got_aw && s_got_w) begin
            if (s_bdly == 0) begin n_bvalid = 1'b1; n_bresp = 2'($urandom_range(0, 3)); end
            else s_bdly--;
        end
        if (ar_hs) s_got_ar = 1'b1;
        if (r_hs) begin
            n_rvalid = 1'b0; s_got_ar = 1'b0;
        end else if (!rvalid && s_got_ar) begin
            if (s_rdly == 0) begin
                n_rvalid = 1'b1; n_rdata = $urandom; n_rresp = 2'($urandom_range(0, 3));
            end else s_rdly--;
        end

        case (m_st)
            M_IDLE: begin
                if (req != '0) begin
                    found = 1'b0; win = last_win;
                    for (int k = 1; k <= NREQ; k++) begin
                        cand = (last_win + k) % NREQ;
                        if (!found && req[cand]) begin found = 1'b1; win = cand; end
                    end
                    m_owner = win; last_win = win; m_we = we[win];
                    m_addr = addr[win*AW +: AW]; m_wdata = wdata[win*DW +: DW];
                    aw_pend = m_we; w_pend = m_we; ar_pend = !m_we; m_st = M_XFER;
                    s_bdly = fast ? 0 : $urandom_range(0, 3);
                    s_rdly = fast ? 0 : $urandom_range(0, 5);
                    if (m_we && !fast && $urandom_range(0, 3) == 0) begin
                        n_bvalid = 1'b1; n_bresp = 2'($urandom_range(0, 3));
                    end
                end
            end
            M_XFER: begin
                if (aw_pend && awready) aw_pend = 1'b0;
                if (w_pend && wready)   w_pend  = 1'b0;
                if (ar_pend && arready) ar_pend = 1'b0;
                if (exp_bready && bvalid) begin m_st = M_DONE; m_err = bresp[1]; end
                if (exp_rready && rvalid) begin
                    m_st = M_DONE; m_err = rresp[1]; exp_rdata = axi_rdata;
                end
            end
            default: begin
                n_xfer++;
                $display("[TB] xfer %0d client %0d %s addr=0x%08h data=0x%08h err=%0d",
                         n_xfer, m_owner, m_we ? "WR" : "RD", m_addr,
                         m_we ? m_wdata : exp_rdata, m_err);
                m_st = M_IDLE;
                n_req[m_owner] = 1'b0;
                dropped[m_owner] = 1'b1;
            end
        endcase

        // owner may abandon or scribble over its inputs; the captured command must stand
        if (m_st == M_XFER) begin
            if ($urandom_range(0, 29) == 0) n_req[m_owner] = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                n_addr[m_owner*AW +: AW]  = $urandom;
                n_wdata[m_owner*DW +: DW] = $urandom;
                n_we[m_owner]             = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!n_req[i] && !dropped[i] && !(m_st != M_IDLE && i == m_owner) &&
                (contend || $urandom_range(0, 3) == 0)) begin
                n_req[i] = 1'b1;
                n_we[i]  = 1'($urandom_range(0, 1));
                n_addr[i*AW +: AW]  = $urandom & 32'hFFFF_FFFC;
                n_wdata[i*DW +: DW] = $urandom;
            end
        end

        if (rst_pending && in_waddr) begin
            #2;
            xrst = 1'b1;
            #1;
            check("rst_awvalid", awvalid, 1'b0);
            check("rst_wvalid", wvalid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, '0);
            check("rst_owner", owner, 0);
            model_reset();
            rst_pending = 1'b0;
        end
    endtask

    initial begin
        fast = 1'b1; contend = 1'b1; rst_pending = 1'b0;
        n_req = '0; n_we = '0; n_addr = '0; n_wdata = '0;
        n_awready = 1'b0; n_wready = 1'b0; n_arready = 1'b0;
        n_bresp = 2'b00; n_rresp = 2'b00; n_rdata = '0;
        model_reset();
        apply();
        xrst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_owner", owner, 0);
        check("reset_done", done, '0);
        check("reset_rdata", rdata_o, '0);
        check("reset_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        @(posedge clk);
        #1;
        xrst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 300) fast = 1'b0;
            if (c == 600) contend = 1'b0;
            if (c == 900 || c == 1800) rst_pending = 1'b1;
            if (c == 2400) contend = 1'b1;
            @(negedge clk);
            eval_cycle();
            @(posedge clk);
            #1;
            apply();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
